// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Width of a core index; never below one bit so the index port always exists.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dm_arbiter_picker.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping mod N.
module rr_priority_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising per-core data-memory requests onto one single-port RAM.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CORES-1:0]            core_req,
  input  logic [N_CORES-1:0]            core_wr,
  input  logic [N_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [N_CORES*DATA_WIDTH-1:0] core_wdata,
  output logic [N_CORES-1:0]            core_ack,
  output logic [DATA_WIDTH-1:0]         core_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int unsigned IDX_W = idx_width(N_CORES);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_priority_picker #(
    .N(N_CORES),
    .W(IDX_W)
  ) u_picker (
    .req  (core_req),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Outputs are driven on the transition into the state that owns them, so
  // mem_en is high throughout ISSUE and core_ack throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      core_ack   <= '0;
      core_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      core_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            idx_q     <= pick_idx;
            wr_q      <= core_wr[pick_idx];
            mem_en    <= 1'b1;
            mem_we    <= core_wr[pick_idx];
            mem_addr  <= core_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= core_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (wr_q) begin
            core_ack[idx_q] <= 1'b1;
            state           <= DONE;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          core_rdata      <= mem_rdata;
          core_ack[idx_q] <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          rr_ptr <= (idx_q == IDX_W'(N_CORES - 1)) ? '0 : idx_q + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a synchronous single-port RAM model.
module tb_dm_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    core_req;
  logic [N-1:0]    core_wr;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_ack;
  logic [DW-1:0]   core_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [7:0] ram [256];

  int unsigned n_checks;
  int unsigned n_errors;

  int unsigned ack_idx [$];
  int unsigned ack_cyc [$];
  int unsigned ack_rd  [$];

  dm_arbiter #(
    .N_CORES   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .core_wr   (core_wr),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_ack  (core_ack),
    .core_rdata(core_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int unsigned i, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_wr[i]               = wr;
    core_addr[i*AW +: AW]    = a;
    core_wdata[i*DW +: DW]   = d;
    core_req[i]              = 1'b1;
  endtask

  // Records up to n acks; optionally the acked core drops its request.
  task automatic run_acks(input int unsigned n, input bit drop);
    int unsigned got;
    int unsigned cyc;
    got = 0;
    cyc = 0;
    ack_idx.delete();
    ack_cyc.delete();
    ack_rd.delete();
    while (got < n && cyc < 200) begin
      tick();
      cyc++;
      if (core_ack != '0) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (core_ack[i]) begin
            ack_idx.push_back(i);
            ack_cyc.push_back(cyc);
            ack_rd.push_back(32'(core_rdata));
            if (drop) core_req[i] = 1'b0;
          end
        end
        got++;
      end
    end
    check("ack_count", got, n);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    core_req   = '0;
    core_wr    = '0;
    core_addr  = '0;
    core_wdata = '0;
    mem_rdata  = '0;
    for (int unsigned i = 0; i < 256; i++) ram[i] = 8'h00;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_ack",   32'(core_ack),   32'h0);
    check("rst_rdata", 32'(core_rdata), 32'h0);
    check("rst_en",    32'(mem_en),     32'h0);
    check("rst_we",    32'(mem_we),     32'h0);
    check("rst_addr",  32'(mem_addr),   32'h0);
    check("rst_wdata", 32'(mem_wdata),  32'h0);
    rst = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("idle_en", 32'(mem_en), 32'h0);
    end

    // Single write, core 1
    set_core(1, 1'b1, 16'h0040, 8'hA5);
    tick();
    check("wr_en",    32'(mem_en),    32'h1);
    check("wr_we",    32'(mem_we),    32'h1);
    check("wr_addr",  32'(mem_addr),  32'h0040);
    check("wr_wdata", 32'(mem_wdata), 32'hA5);
    check("wr_ack0",  32'(core_ack),  32'h0);
    tick();
    check("wr_ack",   32'(core_ack),   32'h2);
    check("wr_en_off",32'(mem_en),     32'h0);
    check("wr_rdata", 32'(core_rdata), 32'h0);
    core_req[1] = 1'b0;
    tick();
    check("wr_ack_pulse", 32'(core_ack), 32'h0);
    check("wr_ram",   32'(ram[8'h40]), 32'hA5);

    // Single read, core 2
    ram[8'h40] = 8'h3C;
    set_core(2, 1'b0, 16'h0040, 8'h00);
    tick();
    check("rd_en",   32'(mem_en),   32'h1);
    check("rd_we",   32'(mem_we),   32'h0);
    check("rd_addr", 32'(mem_addr), 32'h0040);
    tick();
    check("rd_ack0", 32'(core_ack), 32'h0);
    check("rd_en_off", 32'(mem_en), 32'h0);
    tick();
    check("rd_ack",   32'(core_ack),   32'h4);
    check("rd_rdata", 32'(core_rdata), 32'h3C);
    core_req[2] = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(core_ack), 32'h0);

    // Round robin from a fresh pointer: all four cores read continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int unsigned i = 0; i < N; i++) begin
      ram[8'h10 + i] = 8'hC0 + 8'(i);
      set_core(i, 1'b0, AW'(16'h0010 + i), 8'h00);
    end
    run_acks(6, 1'b0);
    core_req = '0;
    if (ack_idx.size() == 6) begin
      for (int unsigned k = 0; k < 6; k++) begin
        check("rr_order", ack_idx[k], k % N);
        check("rr_time",  ack_cyc[k], 3 + 4 * k);
        check("rr_rdata", ack_rd[k], 32'hC0 + (k % N));
      end
    end

    // Pointer now 2: cores 0 and 3 write together -> 3 first, then 0
    set_core(0, 1'b1, 16'h0020, 8'h5A);
    set_core(3, 1'b1, 16'h0023, 8'hE7);
    run_acks(2, 1'b1);
    if (ack_idx.size() == 2) begin
      check("ptr_first",  ack_idx[0], 3);
      check("ptr_second", ack_idx[1], 0);
      check("ptr_t0",     ack_cyc[0], 3);
      check("ptr_t1",     ack_cyc[1], 6);
      check("wr_keeps_rdata", ack_rd[1], 32'hC1);
    end
    check("ptr_ram3", 32'(ram[8'h23]), 32'hE7);
    check("ptr_ram0", 32'(ram[8'h20]), 32'h5A);
    tick();

    // Reset during READ of a core 0 read
    ram[8'h50] = 8'h77;
    set_core(0, 1'b0, 16'h0050, 8'h00);
    tick();
    check("abort_issue", 32'(mem_en), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("abort_en",  32'(mem_en),   32'h0);
    check("abort_ack", 32'(core_ack), 32'h0);
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("abort_noack", 32'(core_ack), 32'h0);
    end
    rst = 1'b0;
    run_acks(1, 1'b1);
    if (ack_idx.size() == 1) begin
      check("fresh_idx",   ack_idx[0], 0);
      check("fresh_time",  ack_cyc[0], 3);
      check("fresh_rdata", ack_rd[0], 32'h77);
    end
    tick();
    check("final_ack", 32'(core_ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
